// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file sequencer: state encoding,
// opcode constants, instruction field positions and opcode classification.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int IMM_LSB = 0;

    function automatic logic [3:0] get_field(input logic [15:0] ir, input int lsb);
        return ir[lsb +: 4];
    endfunction

    // MOV is routed through the ALU as "pass A", so it reads A but not B.
    function automatic logic op_reads_a(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    function automatic logic op_reads_b(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic op_defined(input logic [3:0] op);
        return (op <= OP_LDI) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// 4-bit index to NREG-wide one-hot decoder with enable; indices at or
// beyond NREG decode to all zeros.
module onehot_dec #(
    parameter int NREG = 16
) (
    input  logic [3:0]      i_sel,
    input  logic            i_en,
    output logic [NREG-1:0] o_onehot
);

    // Decode the select index into a single strobe bit when enabled.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_en && (i_sel == 4'(i))) begin
                o_onehot[i] = 1'b1;
            end else begin
                o_onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_sequencer.sv
// Four-phase instruction sequencer driving a one-hot register file, an ALU
// and a result register; all strobes decode from the state and latched IR.
module reg_sequencer
    import cpu_pkg::*;
#(
    parameter int NREG = 16,
    parameter int IW   = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IW-1:0]   instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [NREG-1:0] reg_load,
    output logic [NREG-1:0] reg_oe_a,
    output logic [NREG-1:0] reg_oe_b,
    output logic [3:0]      alu_op,
    output logic            res_load,
    output logic            res_oe,
    output logic            imm_oe,
    output logic [15:0]     imm,
    output logic            done,
    output logic            halted,
    output logic            illegal
);

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_ir;
    logic [3:0]      w_opcode;
    logic            w_en_a;
    logic            w_en_b;
    logic            w_en_d;

    assign w_opcode    = get_field(r_ir[15:0], OPC_LSB);
    assign instr_ready = (r_state == ST_IDLE);
    assign imm         = {8'h00, r_ir[IMM_LSB +: 8]};

    // State and instruction register; IR only loads on an IDLE handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && instr_valid) begin
                r_ir <= instr;
            end else begin
                r_ir <= r_ir;
            end
        end
    end

    // Next-state sequencing; HALT is only left through reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_state_next = ST_DECODE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (w_opcode == OP_HALT) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE:   w_state_next = ST_WRITEBACK;
            ST_WRITEBACK: w_state_next = ST_IDLE;
            ST_HALT:      w_state_next = ST_HALT;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // Per-phase strobe decode; the result register is written in EXECUTE and
    // read back in WRITEBACK, which is what makes rd==ra safe.
    always_comb begin
        w_en_a   = 1'b0;
        w_en_b   = 1'b0;
        w_en_d   = 1'b0;
        alu_op   = 4'h0;
        res_load = 1'b0;
        res_oe   = 1'b0;
        imm_oe   = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_EXECUTE: begin
                alu_op   = w_opcode;
                w_en_a   = op_reads_a(w_opcode);
                w_en_b   = op_reads_b(w_opcode);
                res_load = op_reads_a(w_opcode);
            end
            ST_WRITEBACK: begin
                done    = 1'b1;
                res_oe  = op_reads_a(w_opcode);
                imm_oe  = (w_opcode == OP_LDI);
                w_en_d  = op_reads_a(w_opcode) || (w_opcode == OP_LDI);
                illegal = !op_defined(w_opcode);
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    onehot_dec #(.NREG(NREG)) u_dec_rd (
        .i_sel    (get_field(r_ir[15:0], RD_LSB)),
        .i_en     (w_en_d),
        .o_onehot (reg_load)
    );

    onehot_dec #(.NREG(NREG)) u_dec_ra (
        .i_sel    (get_field(r_ir[15:0], RA_LSB)),
        .i_en     (w_en_a),
        .o_onehot (reg_oe_a)
    );

    onehot_dec #(.NREG(NREG)) u_dec_rb (
        .i_sel    (get_field(r_ir[15:0], RB_LSB)),
        .i_en     (w_en_b),
        .o_onehot (reg_oe_b)
    );

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed and randomized bench for reg_sequencer; expected strobes are
// derived per phase from the instruction word with plain arithmetic.
module tb_reg_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] reg_load;
    logic [15:0] reg_oe_a;
    logic [15:0] reg_oe_b;
    logic [3:0]  alu_op;
    logic        res_load;
    logic        res_oe;
    logic        imm_oe;
    logic [15:0] imm;
    logic        done;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    reg_sequencer #(.NREG(16), .IW(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .reg_load    (reg_load),
        .reg_oe_a    (reg_oe_a),
        .reg_oe_b    (reg_oe_b),
        .alu_op      (alu_op),
        .res_load    (res_load),
        .res_oe      (res_oe),
        .imm_oe      (imm_oe),
        .imm         (imm),
        .done        (done),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Phase 0 = idle, 1 = decode, 2 = execute, 3 = writeback of word w.
    task automatic check_phase(input int ph, input logic [15:0] w);
        logic [3:0]  op, rd, ra, rb;
        logic        uses_a, uses_b, is_ldi, legal;
        logic [15:0] bit_d, bit_a, bit_b;
        op     = w[15:12];
        rd     = w[11:8];
        ra     = w[7:4];
        rb     = w[3:0];
        uses_a = (op >= 4'd1) && (op <= 4'd6);
        uses_b = (op >= 4'd1) && (op <= 4'd5);
        is_ldi = (op == 4'd7);
        legal  = (op <= 4'd7) || (op == 4'd15);
        bit_d  = 16'd1 << rd;
        bit_a  = 16'd1 << ra;
        bit_b  = 16'd1 << rb;
        chk($sformatf("%h p%0d ready", w, ph), 32'(instr_ready), 32'(ph == 0));
        chk($sformatf("%h p%0d oe_a", w, ph), 32'(reg_oe_a), (ph == 2 && uses_a) ? 32'(bit_a) : 32'd0);
        chk($sformatf("%h p%0d oe_b", w, ph), 32'(reg_oe_b), (ph == 2 && uses_b) ? 32'(bit_b) : 32'd0);
        chk($sformatf("%h p%0d alu_op", w, ph), 32'(alu_op), (ph == 2) ? 32'(op) : 32'd0);
        chk($sformatf("%h p%0d res_load", w, ph), 32'(res_load), 32'(ph == 2 && uses_a));
        chk($sformatf("%h p%0d reg_load", w, ph), 32'(reg_load),
            (ph == 3 && (uses_a || is_ldi)) ? 32'(bit_d) : 32'd0);
        chk($sformatf("%h p%0d res_oe", w, ph), 32'(res_oe), 32'(ph == 3 && uses_a));
        chk($sformatf("%h p%0d imm_oe", w, ph), 32'(imm_oe), 32'(ph == 3 && is_ldi));
        chk($sformatf("%h p%0d done", w, ph), 32'(done), 32'(ph == 3));
        chk($sformatf("%h p%0d illegal", w, ph), 32'(illegal), 32'(ph == 3 && !legal));
        chk($sformatf("%h p%0d halted", w, ph), 32'(halted), 32'd0);
        if (ph != 0) begin
            chk($sformatf("%h p%0d imm", w, ph), 32'(imm), 32'({8'h00, w[7:0]}));
        end
    endtask

    // One full instruction; unless held, bus noise is driven after accept.
    task automatic run_instr(input logic [15:0] w, input logic hold);
        @(negedge clock);
        instr       = w;
        instr_valid = 1'b1;
        for (int ph = 1; ph <= 4; ph++) begin
            @(posedge clock);
            #1;
            check_phase(ph % 4, w);
            if (ph < 4) begin
                @(negedge clock);
                if (!hold) begin
                    instr       = 16'($urandom);
                    instr_valid = 1'($urandom);
                end
            end
        end
        if (!hold) begin
            instr_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset       = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        #12;
        check_phase(0, 16'h0000);
        chk("reset imm", 32'(imm), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_instr(16'h1312, 1'b0);
        run_instr(16'h75A5, 1'b0);
        run_instr(16'h9000, 1'b0);
        run_instr(16'h1100, 1'b0);
        run_instr(16'h6F3C, 1'b0);
        run_instr(16'h5FFF, 1'b0);
        run_instr(16'h0ABC, 1'b0);
        run_instr(16'hE123, 1'b0);

        run_instr(16'h2455, 1'b1);
        run_instr(16'h2455, 1'b0);

        // HALT: sticky until reset, later valid instructions ignored.
        @(negedge clock);
        instr       = 16'hF000;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        chk("halt decode halted", 32'(halted), 32'd0);
        chk("halt decode ready", 32'(instr_ready), 32'd0);
        @(negedge clock);
        instr = 16'h1111;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            chk("halt halted", 32'(halted), 32'd1);
            chk("halt ready", 32'(instr_ready), 32'd0);
            chk("halt oe_a", 32'(reg_oe_a), 32'd0);
            chk("halt load", 32'(reg_load), 32'd0);
            chk("halt done", 32'(done), 32'd0);
        end
        @(negedge clock);
        instr_valid = 1'b0;
        reset       = 1'b1;
        #1;
        chk("halt reset ready", 32'(instr_ready), 32'd1);
        chk("halt reset halted", 32'(halted), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset arriving right as WRITEBACK begins aborts the load.
        @(negedge clock);
        instr       = 16'h1312;
        instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("wb reset reg_load", 32'(reg_load), 32'd0);
        chk("wb reset done", 32'(done), 32'd0);
        chk("wb reset ready", 32'(instr_ready), 32'd1);
        @(posedge clock);
        #1;
        chk("wb reset hold load", 32'(reg_load), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_phase(0, 16'h0000);

        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) begin
                w[15:12] = 4'($urandom_range(0, 14));
            end
            run_instr(w, 1'($urandom_range(0, 3) == 0));
        end

        do_reset();
        @(posedge clock);
        #1;
        check_phase(0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
